lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Load/store control stage between the execute stage and the DPI load/store memory port. It accepts one memory op at a time over a valid/ready handshake and checks size and alignment. For loads it issues a single-cycle word read strobe; for stores it issues a single-cycle lane-aligned write strobe with a byte mask. It then waits for rdata_ok or wdata_ok, extracts and extends load data, and presents the result with any exception to writeback over valid/ready.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before an access fault is reported (2..255)

Ports:
clock  in  1  single clock; all state changes on posedge
reset  in  1  synchronous, active-high
in_valid  in  1  op offered by execute
in_ready  out  1  high only in IDLE
in_op  in  4  [3]=store, [2:0]=funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
in_addr  in  32  byte address
in_wdata  in  32  store data, right-justified
ld_wen  out  1  read strobe to memory port, one-cycle pulse
st_wen  out  1  write strobe to memory port, one-cycle pulse
raddr  out  32  {in_addr[31:2],2'b00}, held from REQ through WAIT
waddr  out  32  same word-aligned address as raddr
wmask  out  8  byte-lane mask; [7:4] always 0
wdata  out  32  store data shifted to its byte lane
rdata  in  32  memory word; valid only while rdata_ok=1
rdata_ok  in  1  read complete
wdata_ok  in  1  write complete
out_valid  out  1  result available
out_ready  in  1  writeback accepts result
out_rdata  out  32  extended load data; 0 for stores and exceptions
out_exc  out  2  0 none, 1 misaligned, 2 illegal op, 3 access fault (timeout)
out_badaddr  out  32  faulting byte address; 0 when out_exc=0

Behaviour:
- Reset (synchronous): state=IDLE; all outputs except in_ready are 0; in_ready=1. Reset in any state abandons the op. Strobes drop in the same cycle; late ok pulses are ignored.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered or state-decoded.
- IDLE: on in_valid, latch op, addr and wdata. Check the op:
  - illegal funct3 (011, 110, 111; or store with funct3[2]=1) -> RESP with exc=2.
  - misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> RESP with exc=1.
  - otherwise -> REQ.
  - Exceptions never assert ld_wen or st_wen.
- REQ (exactly 1 cycle): ld_wen=1 for a load or st_wen=1 for a store. Clear the timeout counter. Go to WAIT.
- WAIT: ld_wen and st_wen are 0. Watch rdata_ok for a load, or wdata_ok for a store.
  - On ok: capture data and go to RESP with exc=0.
  - Counter increments each WAIT cycle. When it reaches TIMEOUT-1 with no ok, go to RESP with exc=3.
  - ok arriving in the same cycle as the timeout wins: no exception.
- RESP: out_valid=1 with data stable until out_ready. On out_valid&out_ready go to IDLE. Next op is accepted no earlier than the following cycle; no back-to-back ops.
- wmask: B = 1<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
- wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- Load extract: shift rdata right by 8*addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Ideal memory (ok one cycle after strobe): accept at edge T, strobe during T+1, ok during T+2, out_valid from T+3.
- ok pulses outside WAIT are ignored.

Decomposition:
- Shared package lsu_pkg:
  - op/funct3 constants
  - out_exc codes
  - state enum
- Sub-module lsu_align (combinational): builds wmask and lane-shifted wdata on the store side, and extract plus sign/zero extension on the load side.
- The FSM and timeout counter stay in lsu_mem_ctrl.

Test Plan:
- LW addr 0x80000004, memory word 0xDEADBEEF, ok one cycle after strobe -> raddr 0x80000004; ld_wen high exactly 1 cycle; out_valid 3 cycles after accept; out_rdata 0xDEADBEEF; exc 0.
- LB addr 0x80000003 on 0x80FF1234 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x80000002 -> 0x000080FF.
- SB addr 0x80000001, in_wdata 0x000000AB -> waddr 0x80000000, wmask 0x02, wdata 0xABABABAB, st_wen 1 cycle; out_valid after wdata_ok.
- LH addr 0x80000001 -> no strobe; exc 1; badaddr 0x80000001. in_op 4'b1100 -> exc 2.
- TIMEOUT=16, memory never acks -> exc 3 after 16 WAIT cycles. An ok arriving on the final WAIT cycle -> exc 0.
- out_ready held low 5 cycles in RESP -> outputs stable, in_ready 0. reset asserted during WAIT -> next cycle IDLE, strobes 0, out_valid 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage: funct3 encodings,
// exception codes, FSM state encoding and op-checking helpers.
package lsu_pkg;

    // funct3 encodings carried in in_op[2:0]
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // out_exc codes
    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd2;
    localparam logic [1:0] EXC_ACCESS   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Undefined funct3 values, and unsigned variants on a store, are illegal.
    function automatic logic op_illegal(input logic [3:0] op);
        logic ill;
        case (op[2:0])
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = op[3];
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

    // Halfwords need bit 0 clear, words need bits 1:0 clear; bytes never fault.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic mis;
        case (op[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store stage. Store side produces the lane
// mask and replicated store data; load side shifts the returned word down to
// the addressed byte and sign- or zero-extends it.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_mask_o,
    output logic [31:0] st_lane_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_value_o
);

    logic [31:0] ld_shifted;

    // Store mask and data replication; replication places the data in every
    // lane so the mask alone selects the bytes written.
    always_comb begin
        st_mask_o = 4'b1111;
        st_lane_o = st_data_i;
        case (st_funct3_i[1:0])
            2'b00: begin
                st_mask_o = 4'b0001 << st_addr_lo_i;
                st_lane_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                st_mask_o = 4'b0011 << st_addr_lo_i;
                st_lane_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_mask_o = 4'b1111;
                st_lane_o = st_data_i;
            end
        endcase
    end

    // Load extract: bring the addressed byte/half to bit 0, then extend.
    always_comb begin
        ld_shifted = ld_word_i >> {ld_addr_lo_i, 3'b000};
        case (ld_funct3_i)
            F3_B:    ld_value_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_value_o = {24'd0, ld_shifted[7:0]};
            F3_H:    ld_value_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_value_o = {16'd0, ld_shifted[15:0]};
            default: ld_value_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage. Accepts one op at a time from execute, checks
// size/alignment, pulses a single read or write strobe to the memory port,
// waits for completion (bounded by TIMEOUT) and hands the result plus any
// exception to writeback.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is held with its payload stable until that edge, and
// ready may depend only on the receiver's own state.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        ld_wen,
    output logic        st_wen,
    output logic [31:0] raddr,
    output logic [31:0] waddr,
    output logic [7:0]  wmask,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        rdata_ok,
    input  logic        wdata_ok,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [1:0]  out_exc,
    output logic [31:0] out_badaddr,
    output logic [1:0]  dbg_state
);

    lsu_state_e  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  exc_q, exc_d;
    logic [31:0] badaddr_q, badaddr_d;

    logic [3:0]  al_st_mask;
    logic [31:0] al_st_lane;
    logic [31:0] al_ld_value;
    logic        mem_ok;

    // Store side steers the incoming op at accept time; load side works on
    // the latched op when the memory word returns.
    lsu_align u_align (
        .st_funct3_i  (in_op[2:0]),
        .st_addr_lo_i (in_addr[1:0]),
        .st_data_i    (in_wdata),
        .st_mask_o    (al_st_mask),
        .st_lane_o    (al_st_lane),
        .ld_funct3_i  (op_q[2:0]),
        .ld_addr_lo_i (addr_q[1:0]),
        .ld_word_i    (rdata),
        .ld_value_o   (al_ld_value)
    );

    assign mem_ok = op_q[3] ? wdata_ok : rdata_ok;

    // Next-state and datapath updates for the op lifecycle.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        exc_d     = exc_q;
        badaddr_d = badaddr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d      = in_op;
                    addr_d    = in_addr;
                    wmask_d   = 4'b0000;
                    wdata_d   = 32'd0;
                    rdata_d   = 32'd0;
                    exc_d     = EXC_NONE;
                    badaddr_d = 32'd0;
                    if (op_illegal(in_op)) begin
                        exc_d     = EXC_ILLEGAL;
                        badaddr_d = in_addr;
                        state_d   = ST_RESP;
                    end else if (op_misaligned(in_op, in_addr[1:0])) begin
                        exc_d     = EXC_MISALIGN;
                        badaddr_d = in_addr;
                        state_d   = ST_RESP;
                    end else begin
                        if (in_op[3]) begin
                            wmask_d = al_st_mask;
                            wdata_d = al_st_lane;
                        end
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (mem_ok) begin
                    if (!op_q[3]) begin
                        rdata_d = al_ld_value;
                    end
                    exc_d   = EXC_NONE;
                    state_d = ST_RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    exc_d     = EXC_ACCESS;
                    badaddr_d = addr_q;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 4'd0;
            addr_q    <= 32'd0;
            wmask_q   <= 4'd0;
            wdata_q   <= 32'd0;
            cnt_q     <= 8'd0;
            rdata_q   <= 32'd0;
            exc_q     <= EXC_NONE;
            badaddr_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            exc_q     <= exc_d;
            badaddr_q <= badaddr_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign ld_wen      = (state_q == ST_REQ) && !op_q[3];
    assign st_wen      = (state_q == ST_REQ) && op_q[3];
    assign raddr       = {addr_q[31:2], 2'b00};
    assign waddr       = {addr_q[31:2], 2'b00};
    assign wmask       = {4'b0000, wmask_q};
    assign wdata       = wdata_q;
    assign out_valid   = (state_q == ST_RESP);
    assign out_rdata   = rdata_q;
    assign out_exc     = exc_q;
    assign out_badaddr = badaddr_q;
    assign dbg_state   = state_q;

endmodule
